// File: rtl/sdram_bist.sv
// SDRAM built-in self-test: writes a pattern over 0..last, reads it back and compares.
// Masters the controller's system bus exactly as the host would, one access at a time.
//
// state   | meaning
// IDLE    | waiting for start after reset
// WRITE   | bus_write held until accepted, walks addr 0..last
// READ    | bus_read held until accepted
// WAIT_RD | single outstanding read, waiting for bus_rvalid
// DONE    | status valid, waiting for next start
module sdram_bist #(
    parameter int AW      = 23,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    cfg_mode,
    input  logic [AW-1:0] cfg_last_addr,
    input  logic [15:0]   cfg_seed,
    output logic          bus_read,
    output logic          bus_write,
    output logic [AW-1:0] bus_addr,
    output logic [15:0]   bus_wdata,
    output logic          bus_burst,
    output logic [2:0]    bus_burst_len,
    output logic [1:0]    bus_byteenable,
    input  logic          bus_ready,
    input  logic          bus_rvalid,
    input  logic [15:0]   bus_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [15:0]   first_err_exp,
    output logic [15:0]   first_err_got
);

    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_q, last_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   seed_q, seed_d;
    logic [1:0]    mode_q, mode_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   err_q, err_d;
    logic [AW-1:0] fe_addr_q, fe_addr_d;
    logic [15:0]   fe_exp_q, fe_exp_d;
    logic [15:0]   fe_got_q, fe_got_d;

    logic [15:0]   pattern;
    logic [15:0]   seed_eff;
    logic          at_last;
    logic          in_busy;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_comb begin
        pattern = 16'h0000;
        case (mode_q)
            2'd0: pattern = addr_q[15:0];
            2'd1: pattern = ~addr_q[15:0];
            2'd2: pattern = lfsr_q;
            2'd3: pattern = addr_q[0] ? 16'hAAAA : 16'h5555;
            default: pattern = 16'h0000;
        endcase
    end

    assign seed_eff = (cfg_seed == 16'h0000) ? 16'hACE1 : cfg_seed;
    assign at_last  = (addr_q == last_q);
    assign in_busy  = (state_q == WRITE) || (state_q == READ) || (state_q == WAIT_RD);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        lfsr_d    = lfsr_q;
        seed_d    = seed_q;
        mode_d    = mode_q;
        wd_d      = in_busy ? wd_q + 1'b1 : '0;
        timeout_d = timeout_q;
        err_d     = err_q;
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d    = cfg_mode;
                    last_d    = cfg_last_addr;
                    seed_d    = seed_eff;
                    lfsr_d    = seed_eff;
                    addr_d    = '0;
                    wd_d      = '0;
                    timeout_d = 1'b0;
                    err_d     = 16'h0000;
                    fe_addr_d = '0;
                    fe_exp_d  = 16'h0000;
                    fe_got_d  = 16'h0000;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (bus_ready) begin
                    wd_d = '0;
                    if (at_last) begin
                        addr_d  = '0;
                        lfsr_d  = seed_q;
                        state_d = READ;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                end else if (wd_q == WD_LIMIT) begin
                    wd_d      = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            READ: begin
                if (bus_ready) begin
                    wd_d    = '0;
                    state_d = WAIT_RD;
                end else if (wd_q == WD_LIMIT) begin
                    wd_d      = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            WAIT_RD: begin
                if (bus_rvalid) begin
                    wd_d = '0;
                    if (bus_rdata != pattern) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
                        if (err_q == 16'h0000) begin
                            fe_addr_d = addr_q;
                            fe_exp_d  = pattern;
                            fe_got_d  = bus_rdata;
                        end
                    end
                    if (at_last) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        lfsr_d  = lfsr_step(lfsr_q);
                        state_d = READ;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    wd_d      = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            last_q    <= '0;
            lfsr_q    <= 16'h0000;
            seed_q    <= 16'h0000;
            mode_q    <= 2'd0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            err_q     <= 16'h0000;
            fe_addr_q <= '0;
            fe_exp_q  <= 16'h0000;
            fe_got_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            mode_q    <= mode_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    // All bus outputs decode directly from registers, so they hold steady while stalled.
    assign bus_write      = (state_q == WRITE);
    assign bus_read       = (state_q == READ);
    assign bus_addr       = addr_q;
    assign bus_wdata      = (state_q == WRITE) ? pattern : 16'h0000;
    assign bus_burst      = 1'b0;
    assign bus_burst_len  = 3'd0;
    assign bus_byteenable = 2'b11;

    assign busy           = in_busy;
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 16'h0000) && !timeout_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;

endmodule
